dmem_port_arbiter: RTL

- Shares the single-port 256 x 16 data memory between two requesters: requester 0 (the CPU control state machine's Load/Store path) and requester 1 (program loader / debug port).
- Round-robin arbitration, burst transfers of 1–4 words with address auto-increment, and fixed one-cycle read-data return.
- Sits between the requesters and the memory's D_addr / D_wr / write-data / read-data pins.

---
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-requester round-robin arbiter for the single-port data memory.
// Serves bursts of 1..4 beats with address auto-increment and one-cycle read return.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LEN_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [LEN_W-1:0]  len0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [LEN_W-1:0]  len1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e              state_q, state_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
   logic                rd_pend_q, rd_pend_d;
   logic                rd_owner_q, rd_owner_d;
   logic                winner;
   logic [ADDR_W-1:0]   beat_addr;

   // Natural ADDR_W-bit overflow gives the required wrap from the top address to zero.
   assign beat_addr = base_q + ADDR_W'(beat_cnt_q);

   always_comb begin
      if (req0 && req1) begin
         winner = ~last_owner_q;
      end else begin
         winner = req1;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_d         = wr_q;
      base_d       = base_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_hold_d  = addr_hold_q;
      rd_pend_d    = 1'b0;
      rd_owner_d   = owner_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      mem_wr       = 1'b0;
      mem_wdata    = '0;
      mem_addr     = addr_hold_q;

      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               owner_d    = winner;
               wr_d       = winner ? wr1 : wr0;
               base_d     = winner ? addr1 : addr0;
               len_d      = winner ? len1 : len0;
               beat_cnt_d = '0;
               state_d    = StBusy;
            end
         end
         StBusy: begin
            mem_addr    = beat_addr;
            addr_hold_d = beat_addr;
            mem_wr      = wr_q;
            mem_wdata   = owner_q ? wdata1 : wdata0;
            gnt0        = ~owner_q;
            gnt1        = owner_q;
            rd_pend_d   = ~wr_q;
            if (beat_cnt_q == len_q) begin
               last_owner_d = owner_q;
               state_d      = StIdle;
            end else begin
               beat_cnt_d = beat_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         wr_q         <= 1'b0;
         base_q       <= '0;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         addr_hold_q  <= '0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_q         <= wr_d;
         base_q       <= base_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_hold_q  <= addr_hold_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   // Memory data is already one cycle behind the address, so it passes straight through.
   assign rdata   = rd_pend_q ? mem_rdata : '0;
   assign rvalid0 = rd_pend_q & ~rd_owner_q;
   assign rvalid1 = rd_pend_q & rd_owner_q;
   assign busy    = (state_q == StBusy);
   assign owner   = owner_q;

endmodule
